// File: rtl/spi_byte_engine.sv
// rtl/spi_byte_engine.sv - SPI mode 0 byte engine with valid/ready byte input and chip-select framing
module spi_byte_engine #(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 8,
   parameter int CS_GAP  = 2
) (
   input  logic              p_clk,
   input  logic              p_reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_last,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              s_clk,
   output logic              s_css,
   output logic              s_mosi,
   input  logic              s_miso
);

   localparam int MAX_CNT = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int TICK_W  = $clog2(2 * DATA_W + 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [TICK_W-1:0]   ticks;
   logic [DATA_W-1:0]   tx_sh;
   logic [DATA_W-1:0]   rx_sh;
   logic                last_q;

   always_ff @(posedge p_clk) begin
      if (p_reset) begin
         state    <= IDLE;
         cnt      <= '0;
         ticks    <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         last_q   <= 1'b0;
         tx_ready <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         busy     <= 1'b0;
         s_clk    <= 1'b0;
         s_css    <= 1'b1;
         s_mosi   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               s_css <= 1'b1;
               s_clk <= 1'b0;
               if (tx_valid && tx_ready) begin
                  tx_sh    <= tx_data;
                  last_q   <= tx_last;
                  cnt      <= '0;
                  tx_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= SETUP;
               end else begin
                  tx_ready <= 1'b1;
               end
            end
            // The setup window's final edge doubles as the first rising tick.
            SETUP: begin
               s_css  <= 1'b0;
               s_mosi <= tx_sh[DATA_W-1];
               if (cnt == CNT_W'(CLK_DIV)) begin
                  s_clk <= 1'b1;
                  rx_sh <= {rx_sh[DATA_W-2:0], s_miso};
                  ticks <= TICK_W'(1);
                  cnt   <= '0;
                  state <= SHIFT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (cnt == CNT_W'(CLK_DIV - 1)) begin
                  cnt   <= '0;
                  ticks <= ticks + 1'b1;
                  if (ticks[0]) begin
                     s_clk  <= 1'b0;
                     tx_sh  <= tx_sh << 1;
                     s_mosi <= tx_sh[DATA_W-2];
                     if (ticks == TICK_W'(2 * DATA_W - 1)) begin
                        rx_data  <= rx_sh;
                        rx_valid <= 1'b1;
                        tx_ready <= ~last_q;
                        state    <= last_q ? HOLD : WAIT;
                     end
                  end else begin
                     s_clk <= 1'b1;
                     rx_sh <= {rx_sh[DATA_W-2:0], s_miso};
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT: begin
               s_css <= 1'b0;
               s_clk <= 1'b0;
               if (tx_valid && tx_ready) begin
                  tx_sh    <= tx_data;
                  last_q   <= tx_last;
                  s_mosi   <= tx_data[DATA_W-1];
                  cnt      <= '0;
                  tx_ready <= 1'b0;
                  state    <= SETUP;
               end else begin
                  tx_ready <= 1'b1;
               end
            end
            HOLD: begin
               if (cnt == CNT_W'(CLK_DIV - 1)) begin
                  s_css <= 1'b1;
                  cnt   <= '0;
                  state <= GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               s_css <= 1'b1;
               if (cnt == CNT_W'(CS_GAP - 1)) begin
                  cnt      <= '0;
                  busy     <= 1'b0;
                  tx_ready <= 1'b1;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
